// File: rtl/ddr_axi_pattern_master.sv
// AXI-style bring-up traffic master: writes address-pattern bursts, reads them back, counts mismatches.
// Optional DDR_MASTER_RANDOM_STALL_EN adds LFSR-driven bubbles on WR data valid / RD data ready.
module ddr_axi_pattern_master #(
  parameter logic [3:0]  ID         = 4'h0,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  BURST_LEN  = 8'd15,
  parameter int unsigned NUM_BURSTS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [3:0]  M_WR_ADDR_ID,
  output logic [31:0] M_WR_ADDR_ADDR,
  output logic [7:0]  M_WR_ADDR_LEN,
  output logic [1:0]  M_WR_ADDR_BURST,
  output logic        M_WR_ADDR_VALID,
  input  logic        M_WR_ADDR_READY,
  output logic [31:0] M_WR_DATA,
  output logic [3:0]  M_WR_STRB,
  output logic        M_WR_LAST,
  output logic        M_WR_DATA_VALID,
  input  logic        M_WR_DATA_READY,
  input  logic [3:0]  M_WR_BACK_ID,
  input  logic [1:0]  M_WR_BACK_RESP,
  input  logic        M_WR_BACK_VALID,
  output logic        M_WR_BACK_READY,
  output logic [3:0]  M_RD_ADDR_ID,
  output logic [31:0] M_RD_ADDR_ADDR,
  output logic [7:0]  M_RD_ADDR_LEN,
  output logic [1:0]  M_RD_ADDR_BURST,
  output logic        M_RD_ADDR_VALID,
  input  logic        M_RD_ADDR_READY,
  input  logic [3:0]  M_RD_BACK_ID,
  input  logic [31:0] M_RD_BACK_DATA,
  input  logic [1:0]  M_RD_BACK_DATA_RESP,
  input  logic        M_RD_BACK_DATA_LAST,
  input  logic        M_RD_BACK_DATA_VALID,
  output logic        M_RD_DATA_READY
);

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE} state_t;

  localparam int unsigned   BW          = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BW-1:0] LAST_BURST  = BW'(NUM_BURSTS - 1);
  localparam logic [31:0]   BURST_BYTES = ({24'd0, BURST_LEN} + 32'd1) << 2;

  state_t        state;
  logic          armed;
  logic [BW-1:0] burst_idx;
  logic [7:0]    beat;
  logic [31:0]   burst_addr, beat_addr;
  logic          aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic          bubble, last_beat, w_fire, r_fire, b_bad, r_bad, err_hit;
  logic [15:0]   err_nxt;

`ifdef DDR_MASTER_RANDOM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign bubble = lfsr[0];
`else
  assign bubble = 1'b0;
`endif

  // Payloads are gated by their VALID so every output reads 0 in reset and idle.
  assign M_WR_ADDR_VALID = aw_valid;
  assign M_WR_ADDR_ID    = aw_valid ? ID : '0;
  assign M_WR_ADDR_ADDR  = aw_valid ? burst_addr : '0;
  assign M_WR_ADDR_LEN   = aw_valid ? BURST_LEN : '0;
  assign M_WR_ADDR_BURST = aw_valid ? 2'b01 : 2'b00;
  assign M_WR_DATA_VALID = w_valid;
  assign M_WR_DATA       = w_valid ? beat_addr : '0;
  assign M_WR_STRB       = w_valid ? 4'hF : 4'h0;
  assign M_WR_LAST       = w_valid & last_beat;
  assign M_WR_BACK_READY = b_ready;
  assign M_RD_ADDR_VALID = ar_valid;
  assign M_RD_ADDR_ID    = ar_valid ? ID : '0;
  assign M_RD_ADDR_ADDR  = ar_valid ? burst_addr : '0;
  assign M_RD_ADDR_LEN   = ar_valid ? BURST_LEN : '0;
  assign M_RD_ADDR_BURST = ar_valid ? 2'b01 : 2'b00;
  assign M_RD_DATA_READY = r_ready & ~bubble;

  always_comb begin
    last_beat = (beat == BURST_LEN);
    w_fire    = w_valid & M_WR_DATA_READY;
    r_fire    = M_RD_DATA_READY & M_RD_BACK_DATA_VALID;
    b_bad     = (M_WR_BACK_RESP != 2'b00) || (M_WR_BACK_ID != ID);
    r_bad     = (M_RD_BACK_DATA != beat_addr) || (M_RD_BACK_DATA_RESP != 2'b00) ||
                (M_RD_BACK_ID != ID) || (M_RD_BACK_DATA_LAST != last_beat);
    err_hit   = ((state == S_WB) && M_WR_BACK_VALID && b_bad) ||
                ((state == S_RD) && r_fire && r_bad);
    err_nxt   = (err_hit && (err_cnt != '1)) ? err_cnt + 16'd1 : err_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      burst_idx  <= '0;
      beat       <= '0;
      burst_addr <= '0;
      beat_addr  <= '0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      b_ready    <= 1'b0;
      ar_valid   <= 1'b0;
      r_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      // armed keeps a start pulse that overlaps reset release from being taken
      armed   <= 1'b1;
      err_cnt <= err_nxt;
      case (state)
        S_IDLE, S_DONE: if (start && armed) begin
          state      <= S_WA;
          aw_valid   <= 1'b1;
          busy       <= 1'b1;
          done       <= 1'b0;
          pass       <= 1'b0;
          err_cnt    <= '0;
          burst_idx  <= '0;
          burst_addr <= BASE_ADDR;
        end
        S_WA: if (M_WR_ADDR_READY) begin
          aw_valid  <= 1'b0;
          state     <= S_WD;
          beat      <= '0;
          beat_addr <= burst_addr;
          w_valid   <= ~bubble;
        end
        S_WD: begin
          if (w_fire) begin
            beat      <= beat + 8'd1;
            beat_addr <= beat_addr + 32'd4;
            if (last_beat) begin
              w_valid <= 1'b0;
              b_ready <= 1'b1;
              state   <= S_WB;
            end else begin
              w_valid <= ~bubble;
            end
          end else if (!w_valid) begin
            w_valid <= ~bubble;
          end
        end
        S_WB: if (M_WR_BACK_VALID) begin
          b_ready <= 1'b0;
          if (burst_idx == LAST_BURST) begin
            burst_idx  <= '0;
            burst_addr <= BASE_ADDR;
            ar_valid   <= 1'b1;
            state      <= S_RA;
          end else begin
            burst_idx  <= burst_idx + BW'(1);
            burst_addr <= burst_addr + BURST_BYTES;
            aw_valid   <= 1'b1;
            state      <= S_WA;
          end
        end
        S_RA: if (M_RD_ADDR_READY) begin
          ar_valid  <= 1'b0;
          r_ready   <= 1'b1;
          beat      <= '0;
          beat_addr <= burst_addr;
          state     <= S_RD;
        end
        S_RD: if (r_fire) begin
          beat      <= beat + 8'd1;
          beat_addr <= beat_addr + 32'd4;
          if (last_beat) begin
            r_ready <= 1'b0;
            if (burst_idx == LAST_BURST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end else begin
              burst_idx  <= burst_idx + BW'(1);
              burst_addr <= burst_addr + BURST_BYTES;
              ar_valid   <= 1'b1;
              state      <= S_RA;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_axi_pattern_master.sv
// Self-checking bench: behavioural DDR slave with fault injection, table of pass scenarios,
// plus directed sequences for reset, restart and start-while-busy.
module tb_ddr_axi_pattern_master;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [3:0]  M_WR_ADDR_ID, M_RD_ADDR_ID;
  logic [31:0] M_WR_ADDR_ADDR, M_RD_ADDR_ADDR, M_WR_DATA;
  logic [7:0]  M_WR_ADDR_LEN, M_RD_ADDR_LEN;
  logic [1:0]  M_WR_ADDR_BURST, M_RD_ADDR_BURST;
  logic        M_WR_ADDR_VALID, M_WR_DATA_VALID, M_WR_LAST, M_WR_BACK_READY;
  logic        M_RD_ADDR_VALID, M_RD_DATA_READY;
  logic [3:0]  M_WR_STRB;
  logic        M_WR_ADDR_READY = 1'b0, M_WR_DATA_READY = 1'b0, M_WR_BACK_VALID = 1'b0;
  logic [3:0]  M_WR_BACK_ID = '0, M_RD_BACK_ID = '0;
  logic [1:0]  M_WR_BACK_RESP = '0, M_RD_BACK_DATA_RESP = '0;
  logic        M_RD_ADDR_READY = 1'b0, M_RD_BACK_DATA_LAST = 1'b0, M_RD_BACK_DATA_VALID = 1'b0;
  logic [31:0] M_RD_BACK_DATA = '0;

  always #5 clk = ~clk;

  ddr_axi_pattern_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt),
    .M_WR_ADDR_ID(M_WR_ADDR_ID), .M_WR_ADDR_ADDR(M_WR_ADDR_ADDR), .M_WR_ADDR_LEN(M_WR_ADDR_LEN),
    .M_WR_ADDR_BURST(M_WR_ADDR_BURST), .M_WR_ADDR_VALID(M_WR_ADDR_VALID),
    .M_WR_ADDR_READY(M_WR_ADDR_READY),
    .M_WR_DATA(M_WR_DATA), .M_WR_STRB(M_WR_STRB), .M_WR_LAST(M_WR_LAST),
    .M_WR_DATA_VALID(M_WR_DATA_VALID), .M_WR_DATA_READY(M_WR_DATA_READY),
    .M_WR_BACK_ID(M_WR_BACK_ID), .M_WR_BACK_RESP(M_WR_BACK_RESP),
    .M_WR_BACK_VALID(M_WR_BACK_VALID), .M_WR_BACK_READY(M_WR_BACK_READY),
    .M_RD_ADDR_ID(M_RD_ADDR_ID), .M_RD_ADDR_ADDR(M_RD_ADDR_ADDR), .M_RD_ADDR_LEN(M_RD_ADDR_LEN),
    .M_RD_ADDR_BURST(M_RD_ADDR_BURST), .M_RD_ADDR_VALID(M_RD_ADDR_VALID),
    .M_RD_ADDR_READY(M_RD_ADDR_READY),
    .M_RD_BACK_ID(M_RD_BACK_ID), .M_RD_BACK_DATA(M_RD_BACK_DATA),
    .M_RD_BACK_DATA_RESP(M_RD_BACK_DATA_RESP), .M_RD_BACK_DATA_LAST(M_RD_BACK_DATA_LAST),
    .M_RD_BACK_DATA_VALID(M_RD_BACK_DATA_VALID), .M_RD_DATA_READY(M_RD_DATA_READY)
  );

  // Fault-injection knobs for the slave model
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  int wr_err_burst = -1, el_burst = -1, el_beat = -1, addr_delay = 0;

  // Slave state and observation counters
  logic [31:0] mem [logic [31:0]];
  int  aw_wait, ar_wait, w_beat, r_beat, b_burst, r_burst;
  int  wr_bursts, rd_bursts, wr_beats, rd_beats, proto_err, w_gaps;
  bit  aw_hold, ar_hold, w_open, b_pending, r_active;
  logic [31:0] aw_hold_addr, ar_hold_addr, w_base, r_addr, first_wdata, last_rdata, a;
  int  n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_counts();
    wr_bursts = 0; rd_bursts = 0; wr_beats = 0; rd_beats = 0; proto_err = 0; w_gaps = 0;
    first_wdata = 32'hFFFF_FFFF; last_rdata = 32'hFFFF_FFFF;
  endtask

  // Slave: drives inputs just after each falling edge, and records the handshakes that the
  // following rising edge will complete (VALIDs are registered, so they are stable here).
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      M_WR_ADDR_READY = 0; M_WR_DATA_READY = 0; M_WR_BACK_VALID = 0; M_RD_ADDR_READY = 0;
      M_RD_BACK_DATA_VALID = 0; M_RD_BACK_DATA_LAST = 0; M_RD_BACK_DATA = '0;
      aw_wait = 0; ar_wait = 0; aw_hold = 0; ar_hold = 0;
      w_open = 0; b_pending = 0; r_active = 0;
    end else begin
      if (M_WR_ADDR_VALID) begin
        if (aw_hold && M_WR_ADDR_ADDR != aw_hold_addr) proto_err++;
        M_WR_ADDR_READY = (aw_wait >= addr_delay); aw_wait++;
      end else begin
        if (aw_hold) proto_err++;
        M_WR_ADDR_READY = 0; aw_wait = 0;
      end
      aw_hold = M_WR_ADDR_VALID && !M_WR_ADDR_READY; aw_hold_addr = M_WR_ADDR_ADDR;
      if (M_RD_ADDR_VALID) begin
        if (ar_hold && M_RD_ADDR_ADDR != ar_hold_addr) proto_err++;
        M_RD_ADDR_READY = (ar_wait >= addr_delay); ar_wait++;
      end else begin
        if (ar_hold) proto_err++;
        M_RD_ADDR_READY = 0; ar_wait = 0;
      end
      ar_hold = M_RD_ADDR_VALID && !M_RD_ADDR_READY; ar_hold_addr = M_RD_ADDR_ADDR;
      M_WR_DATA_READY = 1;
      M_WR_BACK_VALID = b_pending; M_WR_BACK_ID = 4'h0;
      M_WR_BACK_RESP  = (b_pending && b_burst == wr_err_burst) ? 2'b10 : 2'b00;
      a = r_addr + 32'(4 * r_beat);
      M_RD_BACK_DATA_VALID = r_active; M_RD_BACK_ID = 4'h0; M_RD_BACK_DATA_RESP = 2'b00;
      M_RD_BACK_DATA = !r_active ? 32'h0 : (a == corrupt_addr) ? 32'h0 :
                       mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
      M_RD_BACK_DATA_LAST = r_active && (r_beat == 15 || (r_burst == el_burst && r_beat == el_beat));
      if (w_open && !M_WR_DATA_VALID) w_gaps++;
      if (M_WR_BACK_READY && !b_pending) proto_err++;
      if (M_WR_ADDR_VALID && M_WR_ADDR_READY) begin
        if (M_WR_ADDR_ADDR != 32'(wr_bursts * 64) || M_WR_ADDR_LEN != 8'd15 ||
            M_WR_ADDR_BURST != 2'b01 || M_WR_ADDR_ID != 4'h0 || w_open || b_pending || r_active)
          proto_err++;
        w_open = 1; w_beat = 0; w_base = M_WR_ADDR_ADDR;
      end
      if (M_WR_DATA_VALID && M_WR_DATA_READY) begin
        if (!w_open || M_WR_DATA != w_base + 32'(4 * w_beat) || M_WR_STRB != 4'hF ||
            M_WR_LAST != (w_beat == 15)) proto_err++;
        mem[w_base + 32'(4 * w_beat)] = M_WR_DATA;
        if (wr_beats == 0) first_wdata = M_WR_DATA;
        wr_beats++; w_beat++;
        if (w_beat == 16) begin
          w_open = 0; b_pending = 1; b_burst = wr_bursts; wr_bursts++;
        end
      end
      if (M_WR_BACK_VALID && M_WR_BACK_READY) b_pending = 0;
      if (M_RD_ADDR_VALID && M_RD_ADDR_READY) begin
        if (M_RD_ADDR_ADDR != 32'(rd_bursts * 64) || M_RD_ADDR_LEN != 8'd15 ||
            M_RD_ADDR_BURST != 2'b01 || M_RD_ADDR_ID != 4'h0 || r_active || b_pending ||
            wr_bursts != 16) proto_err++;
        r_active = 1; r_addr = M_RD_ADDR_ADDR; r_beat = 0; r_burst = rd_bursts;
      end
      if (M_RD_BACK_DATA_VALID && M_RD_DATA_READY) begin
        last_rdata = M_RD_BACK_DATA; rd_beats++; r_beat++;
        if (r_beat == 16) begin r_active = 0; rd_bursts++; end
      end
    end
  end

  task automatic do_reset();
    rst_n = 0; start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    clear_counts();
  endtask

  task automatic pulse_start();
    @(negedge clk); #2 start = 1;
    @(negedge clk); #2 start = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 6000; n++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_pass(input string name, input logic exp_pass, input logic [15:0] exp_err);
    int bad;
    chk({name, "_pass"},    {31'd0, pass}, {31'd0, exp_pass});
    chk({name, "_err_cnt"}, {16'd0, err_cnt}, {16'd0, exp_err});
    chk({name, "_busy"},    {31'd0, busy}, 32'd0);
    chk({name, "_wr_beats"}, 32'(wr_beats), 32'd256);
    chk({name, "_rd_beats"}, 32'(rd_beats), 32'd256);
    chk({name, "_protocol"}, 32'(proto_err), 32'd0);
    chk({name, "_first_wdata"}, first_wdata, 32'h0);
    chk({name, "_last_rdata"},  last_rdata, 32'h3FC);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (!mem.exists(32'(4 * i)) || mem[32'(4 * i)] != 32'(4 * i)) bad++;
    chk({name, "_mem_pattern"}, 32'(bad), 32'd0);
`ifdef DDR_MASTER_RANDOM_STALL_EN
    chk({name, "_wr_bubbles"}, {31'd0, (w_gaps > 0)}, 32'd1);
`else
    chk({name, "_wr_bubbles"}, 32'(w_gaps), 32'd0);
`endif
  endtask

  typedef struct {
    string       name;
    logic [31:0] corrupt;
    int          wr_err;
    int          elb;
    int          elbeat;
    int          delay;
    logic [15:0] exp_err;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"ideal",        32'hFFFF_FFFF, -1, -1, -1,  0, 16'd0, 1'b1};
    vecs[1] = '{"rd_corrupt",   32'h0000_0044, -1, -1, -1,  0, 16'd1, 1'b0};
    vecs[2] = '{"wr_resp_err",  32'hFFFF_FFFF,  3, -1, -1,  0, 16'd1, 1'b0};
    vecs[3] = '{"early_last",   32'hFFFF_FFFF, -1,  2,  7, 20, 16'd1, 1'b0};
    vecs[4] = '{"multi_cause",  32'h0000_0044, -1,  1,  1,  0, 16'd1, 1'b0};
    vecs[5] = '{"three_faults", 32'h0000_0044,  3, 15,  0,  3, 16'd3, 1'b0};

    do_reset();
    @(negedge clk); #1;
    chk("reset_flags", {29'd0, busy, done, pass}, 32'd0);
    chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("reset_handshake", {27'd0, M_WR_ADDR_VALID, M_WR_DATA_VALID, M_WR_BACK_READY,
                            M_RD_ADDR_VALID, M_RD_DATA_READY}, 32'd0);
    chk("reset_payload", M_WR_ADDR_ADDR | M_WR_DATA | {28'd0, M_WR_STRB}, 32'd0);

    foreach (vecs[i]) begin
      do_reset();
      corrupt_addr = vecs[i].corrupt; wr_err_burst = vecs[i].wr_err;
      el_burst = vecs[i].elb; el_beat = vecs[i].elbeat; addr_delay = vecs[i].delay;
      pulse_start();
      wait_done(vecs[i].name);
      check_pass(vecs[i].name, vecs[i].exp_pass, vecs[i].exp_err);
    end

    // Restart from DONE, with a second start pulse while busy that must be ignored
    corrupt_addr = 32'hFFFF_FFFF; wr_err_burst = -1; el_burst = -1; addr_delay = 0;
    clear_counts();
    pulse_start(); #1;
    chk("restart_done_clear", {30'd0, busy, done}, 32'd2);
    repeat (40) @(negedge clk);
    pulse_start();
    wait_done("restart");
    check_pass("restart", 1'b1, 16'd0);

    // Start overlapping reset release is dropped
    rst_n = 0; repeat (2) @(negedge clk);
    #2 rst_n = 1; start = 1;
    @(negedge clk); #2 start = 0;
    repeat (3) @(negedge clk); #1;
    chk("start_at_release", {30'd0, busy, M_WR_ADDR_VALID}, 32'd0);

    // Reset in the middle of the write data phase of burst 5, then a clean pass
    clear_counts();
    pulse_start();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (wr_bursts == 5 && w_open && w_beat >= 4) break;
    end
    chk("reached_burst5", {31'd0, (wr_bursts == 5 && w_open)}, 32'd1);
    #1 rst_n = 0; #1;
    chk("midpass_reset", {26'd0, busy, M_WR_ADDR_VALID, M_WR_DATA_VALID, M_WR_BACK_READY,
                          M_RD_ADDR_VALID, M_RD_DATA_READY}, 32'd0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1;
    clear_counts();
    pulse_start();
    wait_done("after_reset");
    check_pass("after_reset", 1'b1, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
